// File: rtl/ncl_seq_pkg.sv
// ncl_seq_pkg: shared types for the NCL counter-ring sequencer.
//   state_e  - sequencer FSM states
//   DR_*     - dual-rail pair encodings {rail1, rail0}
package ncl_seq_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    DRIVE  = 3'd2,
    WAIT_D = 3'd3,
    WAIT_N = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

endpackage

// File: rtl/ncl_word_detect.sv
// ncl_word_detect: synchronises the ring's dual-rail sum word and carry-out
// into clk, then classifies the synced word.
// Ports:
//   clk, init_n        clock, async active-low reset (sync bank clears to NULL)
//   ring_sum           dual-rail sum word, bit i on [2i+1:2i]
//   ring_carryout      dual-rail carry from the MSB stage
//   all_data_c         every synced pair (sum and carry) is DATA0/DATA1
//   all_null_c         every synced pair (sum and carry) is NULL
//   illegal_c          some synced pair is 11
//   carry_data1_c      synced carry-out is DATA1
//   sum_bin_c          binary decode of the synced sum word (rail1 of each pair)
module ncl_word_detect
  import ncl_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [2*WIDTH-1:0] ring_sum,
  input  logic [1:0]         ring_carryout,
  output logic               all_data_c,
  output logic               all_null_c,
  output logic               illegal_c,
  output logic               carry_data1_c,
  output logic [WIDTH-1:0]   sum_bin_c
);

  localparam int unsigned RW = 2 * WIDTH + 2;

  // Per-bit synchronisers are safe here: rails only rise in a DATA phase and
  // only fall in a NULL phase, so a late bit is seen late, never wrong.
  logic [RW-1:0] sync_q [SYNC_STAGES];
  logic [RW-1:0] sync_d [SYNC_STAGES];
  logic [RW-1:0] word;
  logic [1:0]    pair;

  // Shift chain, carry-out in the top pair.
  always_comb begin
    sync_d[0] = {ring_carryout, ring_sum};
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  // Word classification and decode of the last sync stage.
  always_comb begin
    word          = sync_q[SYNC_STAGES-1];
    pair          = DR_NULL;
    all_data_c    = 1'b1;
    all_null_c    = 1'b1;
    illegal_c     = 1'b0;
    sum_bin_c     = '0;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      pair = word[2*i +: 2];
      if (!(pair == DR_0 || pair == DR_1)) all_data_c = 1'b0;
      if (pair != DR_NULL)                 all_null_c = 1'b0;
      if (pair == DR_ILL)                  illegal_c  = 1'b1;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_bin_c[i] = word[2*i+1];
    end
    carry_data1_c = (word[RW-1:RW-2] == DR_1);
  end

endmodule

// File: rtl/ncl_counter_sequencer.sv
// ncl_counter_sequencer: clocked controller for the dual-rail NCL counter ring.
// Issues DATA/NULL increment wavefronts on the ring carry-in, acknowledges each
// completed word via ring_sumcomp, and decodes each DATA sum word for the host.
// Optional feature macro: NCL_SEQ_TIMEOUT_EN adds a per-phase watchdog in
// WAIT_D/WAIT_N that halts with error after TIMEOUT cycles without progress.
// Ports:
//   clk, init_n     clock, async active-low reset
//   cmd_valid/ready host burst request / accepted only in IDLE
//   cmd_count       increments in the burst (0 = accepted no-op)
//   ring_init       active-high ring initialisation
//   ring_carryin    dual-rail carry into bit 0
//   ring_sumcomp    word completion acknowledge to the ring
//   ring_sum        dual-rail sum word from the ring
//   ring_carryout   dual-rail carry from the ring MSB
//   count_out       last captured binary count
//   count_valid     one-cycle pulse per capture
//   overflow        sticky, set when a captured carry-out is DATA1
//   busy            high outside IDLE and INIT
//   error           sticky protocol/timeout error
module ncl_counter_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               cmd_valid,
  input  logic [CNT_W-1:0]   cmd_count,
  output logic               cmd_ready,
  output logic               ring_init,
  output logic [1:0]         ring_carryin,
  output logic               ring_sumcomp,
  input  logic [2*WIDTH-1:0] ring_sum,
  input  logic [1:0]         ring_carryout,
  output logic [WIDTH-1:0]   count_out,
  output logic               count_valid,
  output logic               overflow,
  output logic               busy,
  output logic               error
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
`ifdef NCL_SEQ_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic             all_data_c, all_null_c, illegal_c, carry_data1_c;
  logic [WIDTH-1:0] sum_bin_c;

  ncl_word_detect #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_detect (
    .clk           (clk),
    .init_n        (init_n),
    .ring_sum      (ring_sum),
    .ring_carryout (ring_carryout),
    .all_data_c    (all_data_c),
    .all_null_c    (all_null_c),
    .illegal_c     (illegal_c),
    .carry_data1_c (carry_data1_c),
    .sum_bin_c     (sum_bin_c)
  );

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ill_q, ill_d;
  logic              ring_init_q, ring_init_d;
  logic [1:0]        carryin_q, carryin_d;
  logic              sumcomp_q, sumcomp_d;
  logic [WIDTH-1:0]  count_out_q, count_out_d;
  logic              count_valid_q, count_valid_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              in_wait;
  logic              fault;

  // Next state, counters, flags and registered outputs.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    remaining_d   = remaining_q;
    wd_d          = '0;
    ill_d         = illegal_c;
    carryin_d     = carryin_q;
    sumcomp_d     = sumcomp_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    overflow_d    = overflow_q;
    error_d       = error_q;
    in_wait       = (state_q == WAIT_D) || (state_q == WAIT_N);
    fault         = 1'b0;

    unique case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = IDLE;
        else                                        init_cnt_d = init_cnt_q + INIT_W'(1);
      end
      IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_count;
          if (cmd_count != '0) state_d = DRIVE;
        end
      end
      DRIVE: begin
        carryin_d = DR_1;
        state_d   = WAIT_D;
      end
      WAIT_D: begin
        if (all_data_c) begin
          count_out_d   = sum_bin_c;
          count_valid_d = 1'b1;
          overflow_d    = overflow_q | carry_data1_c;
          sumcomp_d     = 1'b1;
          carryin_d     = DR_NULL;
          state_d       = WAIT_N;
        end
      end
      WAIT_N: begin
        if (all_null_c) begin
          sumcomp_d   = 1'b0;
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? IDLE : DRIVE;
        end
      end
      HALT: ;
      default: state_d = HALT;
    endcase

    // Watchdog restarts whenever the phase advances.
    if (in_wait && state_d == state_q) wd_d = wd_q + WD_W'(1);
    if (WD_EN && in_wait && state_d == state_q && wd_q == WD_W'(TIMEOUT - 1)) fault = 1'b1;

    // A single 11 sample may be a sync-time artefact; two in a row is real.
    if (illegal_c && ill_q && state_q != INIT && state_q != HALT) fault = 1'b1;

    if (fault) begin
      state_d   = HALT;
      error_d   = 1'b1;
      carryin_d = DR_NULL;
      sumcomp_d = 1'b0;
    end

    ring_init_d = (state_d == INIT);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != INIT) && (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      remaining_q   <= '0;
      wd_q          <= '0;
      ill_q         <= 1'b0;
      ring_init_q   <= 1'b1;
      carryin_q     <= DR_NULL;
      sumcomp_q     <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      remaining_q   <= remaining_d;
      wd_q          <= wd_d;
      ill_q         <= ill_d;
      ring_init_q   <= ring_init_d;
      carryin_q     <= carryin_d;
      sumcomp_q     <= sumcomp_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign ring_init    = ring_init_q;
  assign ring_carryin = carryin_q;
  assign ring_sumcomp = sumcomp_q;
  assign count_out    = count_out_q;
  assign count_valid  = count_valid_q;
  assign overflow     = overflow_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule
